// File: rtl/gb_video_pkg.sv
// Shared video constants, capture state encoding and palette lookup.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gb_video_pkg;

    localparam int H_RES             = 160;
    localparam int V_RES             = 144;
    localparam int FB_BYTES_PER_LINE = 40;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_LINE   = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } cap_state_e;

    // Map a raw 2-bit colour index to its shade through the BGP register.
    function automatic logic [1:0] palette_shade(input logic [7:0] bgp, input logic [1:0] color);
        logic [1:0] shade;
        shade = 2'd0;
        case (color)
            2'd0:    shade = bgp[1:0];
            2'd1:    shade = bgp[3:2];
            2'd2:    shade = bgp[5:4];
            default: shade = bgp[7:6];
        endcase
        return shade;
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Palette lookup and 4-shade byte packing with zero-padded flush of a partial group.
// Latency: write appears 1 cycle after the 4th pixel or the flush request.
// Backpressure: none; the framebuffer RAM accepts a write every cycle.
module pixel_packer
    import gb_video_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_vld_i,
    input  logic [1:0]    color_i,
    input  logic [7:0]    bgp_i,
    input  logic          flush_i,
    input  logic [AW-1:0] addr_i,
    output logic          fb_we_o,
    output logic [AW-1:0] fb_addr_o,
    output logic [7:0]    fb_wdata_o
);

    logic [5:0]    pack_q, pack_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [1:0]    shade;

    assign shade = palette_shade(bgp_i, color_i);

    // Shift shades in; emit a full byte on the 4th, or a padded byte on flush.
    always_comb begin
        pack_d  = pack_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (pix_vld_i) begin
            pack_d = {pack_q[3:0], shade};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                we_d    = 1'b1;
                addr_d  = addr_i;
                wdata_d = {pack_q, shade};
            end
        end else if (flush_i && cnt_q != 2'd0) begin
            we_d   = 1'b1;
            addr_d = addr_i;
            case (cnt_q)
                2'd1:    wdata_d = {pack_q[1:0], 6'd0};
                2'd2:    wdata_d = {pack_q[3:0], 4'd0};
                default: wdata_d = {pack_q[5:0], 2'd0};
            endcase
            cnt_d  = 2'd0;
            pack_d = 6'd0;
        end
    end

    // Pack state and registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pack_q  <= 6'd0;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'd0;
        end else begin
            pack_q  <= pack_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign fb_we_o    = we_q;
    assign fb_addr_o  = addr_q;
    assign fb_wdata_o = wdata_q;

endmodule

// File: rtl/gb_lcd_capture.sv
// Captures the PPU pixel stream into a packed 2bpp framebuffer and checks line/frame framing.
// Latency: framebuffer write 1 cycle after the completing pixel; status pulses 1 cycle after the edge.
// Backpressure: none; the PPU stream cannot be stalled, so every event is handled in-cycle.
module gb_lcd_capture
    import gb_video_pkg::*;
#(
    parameter int H_RES = gb_video_pkg::H_RES,
    parameter int V_RES = gb_video_pkg::V_RES,
    parameter int FB_AW = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lcd_pixel,
    input  logic [1:0]       lcd_color,
    input  logic             lcd_hsync,
    input  logic             lcd_vsync,
    input  logic [7:0]       bgp,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [7:0]       fb_wdata,
    output logic             frame_done,
    output logic             frame_err,
    output logic             line_err,
    output logic [7:0]       frame_count,
    output logic [7:0]       cur_y
);

    localparam logic [7:0]       H_END     = 8'(H_RES);
    localparam logic [7:0]       V_END     = 8'(V_RES);
    localparam logic [FB_AW-1:0] LINE_STEP = FB_AW'(FB_BYTES_PER_LINE);

    cap_state_e       state_q, state_d;
    logic             hsync_q, vsync_q;
    logic [7:0]       x_q, x_d, y_q, y_d;
    logic [FB_AW-1:0] base_q, base_d;
    logic             err_pend_q, err_pend_d;
    logic             sticky_q, sticky_d;
    logic             line_err_q, line_err_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       fcnt_q, fcnt_d;

    logic             hs_rise, hs_fall, vs_rise, vs_fall;
    logic             accept, pix_err, close, frame_eval, hblank_err, start;
    logic             sticky_nxt, frame_ok;
    logic [7:0]       y_inc, y_after;
    logic [FB_AW-1:0] grp_addr;

    // Edges are seen in the same cycle the sync input changes.
    assign hs_rise = lcd_hsync & ~hsync_q;
    assign hs_fall = ~lcd_hsync & hsync_q;
    assign vs_rise = lcd_vsync & ~vsync_q;
    assign vs_fall = ~lcd_vsync & vsync_q;

    assign grp_addr = base_q + FB_AW'(x_q[7:2]);

    // Framing state machine, line/frame bookkeeping and error pulses.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        pix_err      = 1'b0;
        close        = 1'b0;
        frame_eval   = 1'b0;
        hblank_err   = 1'b0;
        start        = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        base_d       = base_q;
        err_pend_d   = err_pend_q;
        fcnt_d       = fcnt_q;
        y_after      = y_q;
        y_inc        = (y_q == 8'hFF) ? y_q : y_q + 8'd1;

        case (state_q)
            S_SYNC, S_VBLANK: begin
                if (vs_fall) begin
                    start   = 1'b1;
                    state_d = S_LINE;
                end
            end
            S_LINE: begin
                // Pixels past the line end, past the last line, or under hsync are dropped and flagged.
                if (lcd_pixel && !lcd_vsync) begin
                    if (!lcd_hsync && x_q < H_END && y_q < V_END) begin
                        accept = 1'b1;
                    end else begin
                        pix_err = 1'b1;
                    end
                end
                if (vs_rise || hs_rise) begin
                    close      = 1'b1;
                    frame_eval = vs_rise;
                    state_d    = vs_rise ? S_VBLANK : S_HBLANK;
                end
            end
            S_HBLANK: begin
                hblank_err = lcd_pixel;
                if (vs_rise) begin
                    frame_eval = 1'b1;
                    state_d    = S_VBLANK;
                end else if (hs_fall) begin
                    state_d = S_LINE;
                end
            end
            default: state_d = S_SYNC;
        endcase

        if (accept) begin
            x_d = x_q + 8'd1;
        end
        if (pix_err) begin
            err_pend_d = 1'b1;
        end

        line_err_d = (close && (err_pend_q || pix_err || x_q != H_END)) || hblank_err;
        sticky_nxt = sticky_q | line_err_d;
        sticky_d   = sticky_nxt;

        if (close) begin
            x_d        = 8'd0;
            y_d        = y_inc;
            y_after    = y_inc;
            base_d     = base_q + LINE_STEP;
            err_pend_d = 1'b0;
        end

        // A frame closing the same cycle as its last line sees that line's result.
        frame_ok     = (y_after == V_END) && !sticky_nxt;
        frame_done_d = frame_eval && frame_ok;
        frame_err_d  = frame_eval && !frame_ok;
        if (frame_done_d) begin
            fcnt_d = fcnt_q + 8'd1;
        end

        if (start) begin
            x_d        = 8'd0;
            y_d        = 8'd0;
            base_d     = '0;
            err_pend_d = 1'b0;
            sticky_d   = 1'b0;
        end
    end

    // State, counters and registered status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_SYNC;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            base_q       <= '0;
            err_pend_q   <= 1'b0;
            sticky_q     <= 1'b0;
            line_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            fcnt_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            hsync_q      <= lcd_hsync;
            vsync_q      <= lcd_vsync;
            x_q          <= x_d;
            y_q          <= y_d;
            base_q       <= base_d;
            err_pend_q   <= err_pend_d;
            sticky_q     <= sticky_d;
            line_err_q   <= line_err_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            fcnt_q       <= fcnt_d;
        end
    end

    pixel_packer #(
        .AW (FB_AW)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .pix_vld_i  (accept),
        .color_i    (lcd_color),
        .bgp_i      (bgp),
        .flush_i    (close),
        .addr_i     (grp_addr),
        .fb_we_o    (fb_we),
        .fb_addr_o  (fb_addr),
        .fb_wdata_o (fb_wdata)
    );

    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign line_err    = line_err_q;
    assign frame_count = fcnt_q;
    assign cur_y       = y_q;

endmodule
